// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operation sequencer:
// FSM state encoding, unit opcodes and 7-segment digit codes.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CONVERT = 3'd3,
    ST_SHOW    = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;

  localparam logic [4:0] DIG_E     = 5'd14;
  localparam logic [4:0] DIG_R     = 5'd16;
  localparam logic [4:0] DIG_BLANK = 5'd17;

  localparam int NDIG = 3;

  function automatic logic op_is_legal(input logic [2:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_MUL, OP_DIV, OP_AND, OP_OR: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/calc_op_sequencer_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, one shift per cycle for W cycles.
// done and bcd are valid together in the cycle of the final shift.
module bin2bcd_seq #(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    bin,
  output logic            done,
  output logic [4*ND-1:0] bcd
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]      r_bin;
  logic [4*ND-1:0]   r_bcd;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic [4*ND-1:0]   w_adj;
  logic [4*ND+W-1:0] w_sh;

  // add-3 correction on every digit that is 5 or more, then shift left by one
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < ND; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end else begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4];
      end
    end
    w_sh = {w_adj, r_bin} << 1;
  end

  assign done = r_busy & (r_cnt == CW'(W - 1));
  assign bcd  = w_sh[4*ND+W-1:W];

  // conversion shift register and shift counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_bin  <= bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= w_sh[4*ND+W-1:W];
      r_bin <= w_sh[W-1:0];
      r_cnt <= r_cnt + CW'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: runs one calculation through the shared arithmetic unit and
// shows the result as three digit codes. Define CALC_OP_SEQUENCER_LZB_EN for leading-zero blanking.
module calc_op_sequencer #(
  parameter int OPW     = 4,
  parameter int RESW    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            ac,
  input  logic [OPW-1:0]  op_a,
  input  logic [OPW-1:0]  op_b,
  input  logic [2:0]      op_code,
  input  logic            equal_n,
  output logic            alu_start,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  output logic [2:0]      alu_op,
  input  logic            alu_done,
  input  logic [RESW-1:0] alu_result,
  input  logic            alu_err,
  output logic [4:0]      dig2,
  output logic [4:0]      dig1,
  output logic [4:0]      dig0,
  output logic            busy,
  output logic            res_valid
);

  import calc_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_eq_s1;
  logic            r_eq_s2;
  logic            r_eq_d;
  logic            w_press;
  logic            w_in_changed;
  logic            w_conv_start;
  logic            w_conv_done;
  logic [4*NDIG-1:0] w_bcd;
  logic [4:0]      w_d2;
  logic [4:0]      w_d1;
  logic [4:0]      w_d0;

  // button synchronizer; r_eq_d keeps the previous synchronized level for edge detection
  always_ff @(posedge clk or posedge ac) begin
    if (ac) begin
      r_eq_s1 <= 1'b1;
      r_eq_s2 <= 1'b1;
      r_eq_d  <= 1'b1;
    end else begin
      r_eq_s1 <= equal_n;
      r_eq_s2 <= r_eq_s1;
      r_eq_d  <= r_eq_s2;
    end
  end

  assign w_press      = r_eq_d & ~r_eq_s2;
  assign w_in_changed = (op_a != alu_a) | (op_b != alu_b) | (op_code != alu_op);
  assign w_conv_start = (r_state == ST_WAIT) & alu_done & ~alu_err;

  bin2bcd_seq #(
    .W  (RESW),
    .ND (NDIG)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (ac),
    .start (w_conv_start),
    .bin   (alu_result),
    .done  (w_conv_done),
    .bcd   (w_bcd)
  );

  // result digit formatting, optionally suppressing leading zeros
  always_comb begin
    w_d2 = {1'b0, w_bcd[11:8]};
    w_d1 = {1'b0, w_bcd[7:4]};
    w_d0 = {1'b0, w_bcd[3:0]};
`ifdef CALC_OP_SEQUENCER_LZB_EN
    w_d2 = (w_bcd[11:8] == 4'd0) ? DIG_BLANK : {1'b0, w_bcd[11:8]};
    w_d1 = (w_bcd[11:4] == 8'd0) ? DIG_BLANK : {1'b0, w_bcd[7:4]};
`else
    w_d2 = {1'b0, w_bcd[11:8]};
`endif
  end

  // sequencing FSM; outputs are registered together with the state
  always_ff @(posedge clk or posedge ac) begin
    if (ac) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      alu_start <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 3'd0;
      dig2      <= DIG_BLANK;
      dig1      <= DIG_BLANK;
      dig0      <= DIG_BLANK;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (r_state)
        ST_IDLE, ST_SHOW: begin
          if ((r_state == ST_SHOW) && w_in_changed) begin
            r_state   <= ST_IDLE;
            dig2      <= DIG_BLANK;
            dig1      <= DIG_BLANK;
            dig0      <= DIG_BLANK;
            res_valid <= 1'b0;
          end else if (w_press) begin
            alu_a  <= op_a;
            alu_b  <= op_b;
            alu_op <= op_code;
            if (op_is_legal(op_code)) begin
              r_state   <= ST_ISSUE;
              alu_start <= 1'b1;
              busy      <= 1'b1;
              res_valid <= 1'b0;
              dig2      <= DIG_BLANK;
              dig1      <= DIG_BLANK;
              dig0      <= DIG_BLANK;
            end else begin
              r_state   <= ST_SHOW;
              dig2      <= DIG_E;
              dig1      <= DIG_R;
              dig0      <= DIG_R;
              busy      <= 1'b0;
              res_valid <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
          r_cnt   <= '0;
        end
        ST_WAIT: begin
          // a done arriving on the timeout cycle is still honoured
          if (alu_done) begin
            if (alu_err) begin
              r_state   <= ST_SHOW;
              dig2      <= DIG_E;
              dig1      <= DIG_R;
              dig0      <= DIG_R;
              busy      <= 1'b0;
              res_valid <= 1'b1;
            end else begin
              r_state <= ST_CONVERT;
            end
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state   <= ST_SHOW;
            dig2      <= DIG_E;
            dig1      <= DIG_R;
            dig0      <= DIG_R;
            busy      <= 1'b0;
            res_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_CONVERT: begin
          if (w_conv_done) begin
            r_state   <= ST_SHOW;
            dig2      <= w_d2;
            dig1      <= w_d1;
            dig0      <= w_d0;
            busy      <= 1'b0;
            res_valid <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          dig2      <= DIG_BLANK;
          dig1      <= DIG_BLANK;
          dig0      <= DIG_BLANK;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: a behavioural arithmetic unit answers
// alu_start, and expected digit triples are queued per press and compared at res_valid.
module tb_calc_op_sequencer;

  localparam logic [14:0] ERR_DIGITS = {5'd14, 5'd16, 5'd16};

  logic       clk = 1'b0;
  logic       ac  = 1'b1;
  logic [3:0] op_a = 4'd0;
  logic [3:0] op_b = 4'd0;
  logic [2:0] op_code = 3'd0;
  logic       equal_n = 1'b1;
  logic       alu_start;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic       alu_done;
  logic       unit_done = 1'b0;
  logic       late_done = 1'b0;
  logic [7:0] alu_result = 8'd0;
  logic       alu_err = 1'b0;
  logic [4:0] dig2;
  logic [4:0] dig1;
  logic [4:0] dig0;
  logic       busy;
  logic       res_valid;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int unit_delay = 3;
  bit unit_silent = 1'b0;
  int base;
  logic [14:0] sb_q[$];

  assign alu_done = unit_done | late_done;

  calc_op_sequencer dut (
    .clk        (clk),
    .ac         (ac),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_code    (op_code),
    .equal_n    (equal_n),
    .alu_start  (alu_start),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .dig2       (dig2),
    .dig1       (dig1),
    .dig0       (dig0),
    .busy       (busy),
    .res_valid  (res_valid)
  );

  always #5 clk = ~clk;

  function automatic int unit_calc(input int a, input int b, input int op);
    case (op)
      1:       return a + b;
      2:       return a * b;
      3:       return (b == 0) ? 0 : a / b;
      4:       return a & b;
      5:       return a | b;
      default: return 0;
    endcase
  endfunction

  function automatic logic [14:0] fmt(input int v);
    logic [4:0] h;
    logic [4:0] t;
    logic [4:0] u;
    h = 5'(v / 100);
    t = 5'((v / 10) % 10);
    u = 5'(v % 10);
`ifdef CALC_OP_SEQUENCER_LZB_EN
    if (h == 5'd0) begin
      h = 5'd17;
      if (t == 5'd0) t = 5'd17;
    end
`endif
    return {h, t, u};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // behavioural arithmetic unit
  always begin
    int ua, ub, uo;
    @(posedge clk);
    #1;
    if (alu_start === 1'b1) n_start++;
    if (alu_start === 1'b1 && !unit_silent) begin
      ua = int'(alu_a);
      ub = int'(alu_b);
      uo = int'(alu_op);
      repeat (unit_delay) @(posedge clk);
      #1;
      unit_done  = 1'b1;
      alu_result = 8'(unit_calc(ua, ub, uo));
      alu_err    = (uo == 3 && ub == 0);
      @(posedge clk);
      #1;
      unit_done  = 1'b0;
      alu_result = 8'hA5;
      alu_err    = 1'b0;
    end
  end

  // falling edge on equal_n; returns 1ns after the cycle that follows press detection
  task automatic press();
    @(posedge clk);
    #2 equal_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 equal_n = 1'b1;
  endtask

  task automatic set_inputs(input int a, input int b, input int op);
    @(posedge clk);
    #2;
    op_a = 4'(a);
    op_b = 4'(b);
    op_code = 3'(op);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int a, input int b, input int op, input bit err);
    if (err || op < 1 || op > 5 || (op == 3 && b == 0)) sb_q.push_back(ERR_DIGITS);
    else sb_q.push_back(fmt(unit_calc(a, b, op)));
  endtask

  task automatic wait_valid(input string tag, input int budget);
    logic [14:0] e;
    int i;
    i = 0;
    while (res_valid !== 1'b1 && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_dig2"}, 32'(dig2), 32'(e[14:10]));
      check({tag, "_dig1"}, 32'(dig1), 32'(e[9:5]));
      check({tag, "_dig0"}, 32'(dig0), 32'(e[4:0]));
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dig2", 32'(dig2), 32'd17);
    check("rst_dig0", 32'(dig0), 32'd17);
    check("rst_start", 32'(alu_start), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    ac = 1'b0;

    // 7 + 9 with exact latency checks
    set_inputs(7, 9, 1);
    base = n_start;
    push_exp(7, 9, 1, 1'b0);
    press();
    check("add_start", 32'(alu_start), 32'd1);
    check("add_busy", 32'(busy), 32'd1);
    check("add_alu_a", 32'(alu_a), 32'd7);
    repeat (11) @(posedge clk);
    #1;
    check("add_conv_valid", 32'(res_valid), 32'd0);
    check("add_conv_blank", 32'(dig0), 32'd17);
    @(posedge clk);
    #1;
    wait_valid("add", 0);
    check("add_nstart", 32'(n_start - base), 32'd1);

    // input change in SHOW blanks on the next cycle
    @(posedge clk);
    #2 op_a = 4'd6;
    @(posedge clk);
    #1;
    check("chg_valid", 32'(res_valid), 32'd0);
    check("chg_dig0", 32'(dig0), 32'd17);
    check("chg_dig1", 32'(dig1), 32'd17);

    // 15 * 15 = 225, then recalculate the same inputs from SHOW
    set_inputs(15, 15, 2);
    push_exp(15, 15, 2, 1'b0);
    press();
    check("mul_start", 32'(alu_start), 32'd1);
    wait_valid("mul", 100);
    push_exp(15, 15, 2, 1'b0);
    press();
    check("recalc_start", 32'(alu_start), 32'd1);
    check("recalc_blank", 32'(dig0), 32'd17);
    wait_valid("recalc", 100);

    // divide by zero reported by the unit
    set_inputs(9, 0, 3);
    push_exp(9, 0, 3, 1'b0);
    press();
    wait_valid("div0", 100);

    // legal divide
    set_inputs(15, 4, 3);
    push_exp(15, 4, 3, 1'b0);
    press();
    wait_valid("div", 100);

    // illegal opcode: no unit transaction, error shown right away
    set_inputs(3, 3, 6);
    base = n_start;
    push_exp(3, 3, 6, 1'b0);
    press();
    wait_valid("illegal", 0);
    repeat (10) @(posedge clk);
    #1;
    check("illegal_nstart", 32'(n_start - base), 32'd0);

    // logical or
    set_inputs(12, 3, 5);
    push_exp(12, 3, 5, 1'b0);
    press();
    wait_valid("or", 100);

    // unit never answers: timeout boundary, then a late done is ignored
    set_inputs(3, 4, 1);
    unit_silent = 1'b1;
    push_exp(3, 4, 1, 1'b1);
    press();
    repeat (64) @(posedge clk);
    #1;
    check("tmo_early", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1;
    wait_valid("tmo", 0);
    unit_silent = 1'b0;
    base = n_start;
    late_done = 1'b1;
    @(posedge clk);
    #1 late_done = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("late_valid", 32'(res_valid), 32'd1);
    check("late_dig2", 32'(dig2), 32'd14);
    check("late_dig0", 32'(dig0), 32'd16);
    check("late_nstart", 32'(n_start - base), 32'd0);

    // second press while waiting produces no extra start
    set_inputs(8, 8, 1);
    unit_delay = 20;
    base = n_start;
    push_exp(8, 8, 1, 1'b0);
    press();
    repeat (3) @(posedge clk);
    press();
    wait_valid("wpress", 100);
    check("wpress_nstart", 32'(n_start - base), 32'd1);

    // reset during conversion
    unit_delay = 3;
    set_inputs(5, 5, 2);
    press();
    repeat (6) @(posedge clk);
    #1 ac = 1'b1;
    #1;
    check("ac_busy", 32'(busy), 32'd0);
    check("ac_alu_a", 32'(alu_a), 32'd0);
    check("ac_alu_op", 32'(alu_op), 32'd0);
    check("ac_dig1", 32'(dig1), 32'd17);
    check("ac_valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    #2 ac = 1'b0;
    base = n_start;
    repeat (20) @(posedge clk);
    #1;
    check("ac_nstart", 32'(n_start - base), 32'd0);
    check("ac_idle_valid", 32'(res_valid), 32'd0);
    check("ac_idle_dig2", 32'(dig2), 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Controller that sequences one calculation through the shared multi-cycle arithmetic unit.
- Takes operands and opcode from the switches and the active-low "=" button.
- Issues a start/done transaction to the unit, then converts the binary result to three digit codes with a sequential double-dabble.
- Drives the result digit codes consumed by the existing 7-segment decoders: 0-9 digits, 14 = "E", 16 = "r", 17 = blank.

Parameters:
- OPW, 4, operand width in bits.
- RESW, 8, unit result width in bits; 3 BCD digits cover the maximum value 255.
- TIMEOUT, 64, cycles to wait for alu_done before declaring an error.

Ports:
- clk  in  1  system clock.
- ac  in  1  asynchronous reset, active-high.
- op_a  in  OPW  operand A switches.
- op_b  in  OPW  operand B switches.
- op_code  in  3  operation select: 1 add, 2 mul, 3 div, 4 logical and, 5 logical or; others illegal.
- equal_n  in  1  "=" push button, active-low, asynchronous to clk.
- alu_start  out  1  one-cycle start pulse to the unit.
- alu_a  out  OPW  latched operand A.
- alu_b  out  OPW  latched operand B.
- alu_op  out  3  latched opcode.
- alu_done  in  1  one-cycle completion pulse from the unit.
- alu_result  in  RESW  result, valid while alu_done=1.
- alu_err  in  1  error flag from the unit (for example divide by zero), valid while alu_done=1.
- dig2, dig1, dig0  out  5 each  result digit codes, hundreds/tens/units.
- busy  out  1  high in every state other than IDLE and SHOW.
- res_valid  out  1  high in SHOW only.

Behaviour:
- Reset values: all outputs 0, except dig2/dig1/dig0 = 17 (blank). State = IDLE.
- Button handling:
  - equal_n passes through a 2-flop synchronizer.
  - A press is the cycle in which the synchronized value goes 1->0.
  - The synchronizer flops reset to 1.
- States: IDLE, ISSUE, WAIT, CONVERT, SHOW.
- IDLE:
  - Digits are blank.
  - On a press: latch op_a, op_b and op_code into alu_a, alu_b and alu_op; go to ISSUE.
  - If op_code is illegal (0, 6, 7): skip the unit, load digits 14/16/16, go to SHOW.
- ISSUE: alu_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - Count cycles.
  - alu_done=1 with alu_err=0: capture alu_result and go to CONVERT.
  - alu_done=1 with alu_err=1: load 14/16/16 and go to SHOW.
  - Counter reaches TIMEOUT with no done: load 14/16/16 and go to SHOW.
  - alu_done arriving in the same cycle the counter reaches TIMEOUT: alu_done wins.
- CONVERT:
  - Double-dabble, one shift per cycle, exactly RESW cycles. Digits stay blank during conversion.
  - Then write the BCD digits to dig2..dig0 and go to SHOW.
- SHOW:
  - Hold the digits.
  - A new press re-latches the inputs and goes to ISSUE; this allows the same inputs to be recalculated.
  - If op_a, op_b or op_code differs from the latched values: blank the digits and return to IDLE. This takes priority over a press in the same cycle.
- Presses during ISSUE, WAIT or CONVERT are ignored and not queued. Input changes during these states are ignored; the latched values are used.
- alu_done outside WAIT is ignored.
- Latency for a legal op: press-detect cycle -> alu_start asserted in the next cycle. alu_done -> res_valid asserted RESW+1 cycles later.
- Reset asserted mid-operation: immediate return to reset values. No alu_start is generated after reset is released until a new press.

Optional Feature:
- Macro: CALC_OP_SEQUENCER_LZB_EN.
- When defined: leading-zero blanking on the result. dig2 shows 17 when the hundreds digit is 0; dig1 shows 17 when both hundreds and tens are 0. dig0 is always shown. Error codes are never blanked.
- When undefined: all three digits are always shown, including leading zeros.

Decomposition:
- Shared package calc_pkg holds:
  - the state enum;
  - the opcode constants OP_ADD=1, OP_MUL=2, OP_DIV=3, OP_AND=4, OP_OR=5;
  - the digit constants DIG_E=14, DIG_R=16, DIG_BLANK=17.
- One sub-module, bin2bcd_seq: sequential double-dabble with a start/done handshake, instantiated once by the sequencer.

Test Plan:
- Reset, then op_a=7, op_b=9, op_code=1, press; model unit answers 16 after 3 cycles -> one alu_start pulse, digits 0/1/6 (LZB: 17/1/6), res_valid high.
- op_a=15, op_b=15, op_code=2 -> result 225 -> digits 2/2/5.
- op_code=3, op_b=0, unit returns alu_err=1 -> digits 14/16/16, res_valid=1.
- op_code=6, press -> no alu_start ever; digits 14/16/16 within 2 cycles of the press detect.
- Unit never answers -> after TIMEOUT=64 cycles digits 14/16/16; a late alu_done in SHOW is ignored.
- In SHOW, toggle op_a -> digits blank next cycle, IDLE, res_valid=0. Separately: press during WAIT -> exactly one alu_start; assert ac during CONVERT -> all outputs at reset values, blank digits.
